// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: CPU port, DMA/host loader port, RAM port and statistics.
// The arbiter uses the slave modport; requesters and the RAM model use master.
interface ram_arbiter_if;
    logic        cpu_re;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [3:0]  cpu_wdata;
    logic [3:0]  cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [3:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_done;
    logic [3:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [3:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_rdata;
    logic [15:0] stall_count;

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, dma_gnt, dma_done, dma_rdata, mem_addr, mem_wdata, mem_re, mem_we,
               stall_count
    );

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, dma_gnt, dma_done, dma_rdata, mem_addr, mem_wdata, mem_re, mem_we,
               stall_count
    );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates one 4-bit single-port RAM between the CPU and a DMA loader with wait states.
// Define RAM_ARB_STATS_EN to build the saturating CPU stall-cycle counter.
module ram_arbiter #(
    parameter int WAIT_STATES   = 1,
    parameter int CPU_BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    localparam int BW = $clog2(CPU_BURST_MAX + 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      wait_cnt_reg, wait_cnt_next;
    logic [BW-1:0]   burst_cnt_reg;
    logic            owner_dma_reg;
    logic            lat_we_reg;
    logic [15:0]     lat_addr_reg;
    logic [3:0]      lat_wdata_reg;
    logic [3:0]      cpu_rdata_reg;
    logic [3:0]      dma_rdata_reg;
    logic            dma_done_reg;

    logic            cpu_req, dma_wins, cpu_wins, grant, idle, active, own_dma;
    logic            cur_we, last_cycle, final_cyc, cpu_final_rd, cpu_stall_int;
    logic [15:0]     cur_addr;
    logic [3:0]      cur_wdata;

    // Arbitration and current-access view; in IDLE the winner is used directly.
    always_comb begin
        cpu_req    = bus.cpu_re | bus.cpu_we;
        dma_wins   = bus.dma_req & (~cpu_req | (burst_cnt_reg == BW'(CPU_BURST_MAX)));
        cpu_wins   = cpu_req & ~dma_wins;
        idle       = (state_reg == IDLE);
        grant      = idle & (cpu_wins | dma_wins);
        active     = idle ? grant : 1'b1;
        own_dma    = idle ? dma_wins : owner_dma_reg;
        cur_we     = lat_we_reg;
        cur_addr   = lat_addr_reg;
        cur_wdata  = lat_wdata_reg;
        if (grant) begin
            cur_we    = dma_wins ? bus.dma_we    : bus.cpu_we;
            cur_addr  = dma_wins ? bus.dma_addr  : bus.cpu_addr;
            cur_wdata = dma_wins ? bus.dma_wdata : bus.cpu_wdata;
        end
        last_cycle   = idle ? (WAIT_STATES == 0) : (wait_cnt_reg == 3'(WAIT_STATES));
        final_cyc    = active & last_cycle;
        cpu_final_rd = final_cyc & ~own_dma & ~cur_we;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant && WAIT_STATES != 0) begin
                    state_next    = BUSY;
                    wait_cnt_next = 3'd1;
                end
            end
            BUSY: begin
                if (wait_cnt_reg == 3'(WAIT_STATES)) begin
                    state_next    = IDLE;
                    wait_cnt_next = 3'd0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 3'd1;
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 3'd0;
            end
        endcase
    end

    // Latched access copy, burst tracking and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            burst_cnt_reg <= '0;
            owner_dma_reg <= 1'b0;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= 16'd0;
            lat_wdata_reg <= 4'd0;
            cpu_rdata_reg <= 4'd0;
            dma_rdata_reg <= 4'd0;
            dma_done_reg  <= 1'b0;
        end else begin
            if (grant) begin
                owner_dma_reg <= dma_wins;
                lat_we_reg    <= cur_we;
                lat_addr_reg  <= cur_addr;
                lat_wdata_reg <= cur_wdata;
            end
            if (!bus.dma_req || (grant && dma_wins))
                burst_cnt_reg <= '0;
            else if (grant && cpu_wins)
                burst_cnt_reg <= burst_cnt_reg + BW'(1);
            if (cpu_final_rd)
                cpu_rdata_reg <= bus.mem_rdata;
            if (final_cyc && own_dma && !cur_we)
                dma_rdata_reg <= bus.mem_rdata;
            dma_done_reg <= final_cyc & own_dma;
        end
    end

    // Reset forces the RAM strobes off and holds the CPU.
    always_comb begin
        cpu_stall_int = ~rst | (cpu_req & ~(final_cyc & ~own_dma));
        bus.cpu_stall = cpu_stall_int;
        bus.mem_addr  = cur_addr;
        bus.mem_wdata = cur_wdata;
        bus.mem_re    = rst & active & ~cur_we;
        bus.mem_we    = rst & active & cur_we & last_cycle;
        bus.dma_gnt   = rst & active & own_dma;
        bus.cpu_rdata = cpu_final_rd ? bus.mem_rdata : cpu_rdata_reg;
        bus.dma_rdata = dma_rdata_reg;
        bus.dma_done  = dma_done_reg;
    end

`ifdef RAM_ARB_STATS_EN
    logic [15:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_count_reg <= 16'd0;
        else if (cpu_stall_int && stall_count_reg != 16'hFFFF)
            stall_count_reg <= stall_count_reg + 16'd1;
    end

    assign bus.stall_count = stall_count_reg;
`else
    assign bus.stall_count = 16'd0;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: five instances with different wait-state / burst settings,
// each with its own RAM model, exercised one scenario at a time.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter_if i0 ();
    ram_arbiter_if i1 ();
    ram_arbiter_if i2 ();
    ram_arbiter_if ib ();
    ram_arbiter_if iz ();

    ram_arbiter #(.WAIT_STATES(0), .CPU_BURST_MAX(8)) u0 (.clk(clk), .rst(rst), .bus(i0));
    ram_arbiter #(.WAIT_STATES(1), .CPU_BURST_MAX(8)) u1 (.clk(clk), .rst(rst), .bus(i1));
    ram_arbiter #(.WAIT_STATES(2), .CPU_BURST_MAX(8)) u2 (.clk(clk), .rst(rst), .bus(i2));
    ram_arbiter #(.WAIT_STATES(0), .CPU_BURST_MAX(2)) ub (.clk(clk), .rst(rst), .bus(ib));
    ram_arbiter #(.WAIT_STATES(1), .CPU_BURST_MAX(0)) uz (.clk(clk), .rst(rst), .bus(iz));

    logic [3:0] mem0 [0:65535];
    logic [3:0] mem1 [0:65535];
    logic [3:0] mem2 [0:65535];
    logic [3:0] memb [0:65535];
    logic [3:0] memz [0:65535];

    assign i0.mem_rdata = mem0[i0.mem_addr];
    assign i1.mem_rdata = mem1[i1.mem_addr];
    assign i2.mem_rdata = mem2[i2.mem_addr];
    assign ib.mem_rdata = memb[ib.mem_addr];
    assign iz.mem_rdata = memz[iz.mem_addr];

    always @(posedge clk) begin
        if (i0.mem_we) mem0[i0.mem_addr] <= i0.mem_wdata;
        if (i1.mem_we) mem1[i1.mem_addr] <= i1.mem_wdata;
        if (i2.mem_we) mem2[i2.mem_addr] <= i2.mem_wdata;
        if (ib.mem_we) memb[ib.mem_addr] <= ib.mem_wdata;
        if (iz.mem_we) memz[iz.mem_addr] <= iz.mem_wdata;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        next_cycle();
        #1;
        n_chk++; if (i2.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall act=%b exp=1", i2.cpu_stall); end
        n_chk++; if (i2.mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re act=%b exp=0", i2.mem_re); end
        n_chk++; if (iz.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt act=%b exp=0", iz.dma_gnt); end
        n_chk++; if (i1.dma_done !== 1'b0) begin n_fail++; $display("FAIL rst_done act=%b exp=0", i1.dma_done); end
        n_chk++; if (i0.cpu_rdata !== 4'h0) begin n_fail++; $display("FAIL rst_cpu_rdata act=%h exp=0", i0.cpu_rdata); end
        n_chk++; if (ib.dma_rdata !== 4'h0) begin n_fail++; $display("FAIL rst_dma_rdata act=%h exp=0", ib.dma_rdata); end
        n_chk++; if (i2.stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_stall_count act=%h exp=0", i2.stall_count); end
        next_cycle();
        rst = 1'b1;
        #1;
        n_chk++; if (i2.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_release_stall act=%b exp=0", i2.cpu_stall); end
        $display("reset: released");
    endtask

    task automatic test_ws0_cpu();
        next_cycle();
        i0.cpu_we = 1'b1; i0.cpu_addr = 16'h1234; i0.cpu_wdata = 4'h5;
        #1;
        n_chk++; if (i0.mem_we !== 1'b1) begin n_fail++; $display("FAIL ws0_we act=%b exp=1", i0.mem_we); end
        n_chk++; if (i0.mem_addr !== 16'h1234) begin n_fail++; $display("FAIL ws0_waddr act=%h exp=1234", i0.mem_addr); end
        n_chk++; if (i0.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL ws0_wstall act=%b exp=0", i0.cpu_stall); end
        next_cycle();
        i0.cpu_we = 1'b0; i0.cpu_re = 1'b1;
        #1;
        n_chk++; if (i0.mem_re !== 1'b1) begin n_fail++; $display("FAIL ws0_re act=%b exp=1", i0.mem_re); end
        n_chk++; if (i0.cpu_rdata !== 4'h5) begin n_fail++; $display("FAIL ws0_rdata act=%h exp=5", i0.cpu_rdata); end
        n_chk++; if (i0.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL ws0_rstall act=%b exp=0", i0.cpu_stall); end
        next_cycle();
        i0.cpu_re = 1'b0;
        #1;
        n_chk++; if (i0.cpu_rdata !== 4'h5) begin n_fail++; $display("FAIL ws0_rdata_hold act=%h exp=5", i0.cpu_rdata); end
        n_chk++; if (i0.mem_addr !== 16'h1234) begin n_fail++; $display("FAIL ws0_addr_hold act=%h exp=1234", i0.mem_addr); end
        n_chk++; if (i0.mem_re !== 1'b0) begin n_fail++; $display("FAIL ws0_idle_re act=%b exp=0", i0.mem_re); end
        $display("ws0_cpu: write 5 @1234, read back %h", i0.cpu_rdata);
    endtask

    task automatic test_ws2_cpu_read();
        logic exp_stall [3];
        exp_stall[0] = 1'b1; exp_stall[1] = 1'b1; exp_stall[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            i2.cpu_re = 1'b1; i2.cpu_addr = 16'h0040;
            #1;
            n_chk++; if (i2.cpu_stall !== exp_stall[c]) begin n_fail++; $display("FAIL ws2_stall c%0d act=%b exp=%b", c, i2.cpu_stall, exp_stall[c]); end
            n_chk++; if (i2.mem_re !== 1'b1) begin n_fail++; $display("FAIL ws2_re c%0d act=%b exp=1", c, i2.mem_re); end
        end
        n_chk++; if (i2.cpu_rdata !== 4'hA) begin n_fail++; $display("FAIL ws2_rdata act=%h exp=a", i2.cpu_rdata); end
        next_cycle();
        i2.cpu_re = 1'b0;
        #1;
        n_chk++; if (i2.cpu_rdata !== 4'hA) begin n_fail++; $display("FAIL ws2_rdata_hold act=%h exp=a", i2.cpu_rdata); end
`ifdef RAM_ARB_STATS_EN
        n_chk++; if (i2.stall_count !== 16'd2) begin n_fail++; $display("FAIL ws2_stall_count act=%0d exp=2", i2.stall_count); end
`else
        n_chk++; if (i2.stall_count !== 16'd0) begin n_fail++; $display("FAIL ws2_stall_count act=%0d exp=0", i2.stall_count); end
`endif
        $display("ws2_cpu_read: rdata %h stall_count %0d", i2.cpu_rdata, i2.stall_count);
    endtask

    task automatic test_dma_write();
        next_cycle();
        i1.dma_req = 1'b1; i1.dma_we = 1'b1; i1.dma_addr = 16'h00FF; i1.dma_wdata = 4'h3;
        #1;
        n_chk++; if (i1.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dmaw_gnt1 act=%b exp=1", i1.dma_gnt); end
        n_chk++; if (i1.mem_we !== 1'b0) begin n_fail++; $display("FAIL dmaw_we1 act=%b exp=0", i1.mem_we); end
        n_chk++; if (i1.mem_addr !== 16'h00FF) begin n_fail++; $display("FAIL dmaw_addr act=%h exp=00ff", i1.mem_addr); end
        next_cycle();
        #1;
        n_chk++; if (i1.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dmaw_gnt2 act=%b exp=1", i1.dma_gnt); end
        n_chk++; if (i1.mem_we !== 1'b1) begin n_fail++; $display("FAIL dmaw_we2 act=%b exp=1", i1.mem_we); end
        n_chk++; if (i1.mem_wdata !== 4'h3) begin n_fail++; $display("FAIL dmaw_wdata act=%h exp=3", i1.mem_wdata); end
        n_chk++; if (i1.dma_done !== 1'b0) begin n_fail++; $display("FAIL dmaw_done_early act=%b exp=0", i1.dma_done); end
        next_cycle();
        i1.dma_req = 1'b0;
        #1;
        n_chk++; if (i1.dma_done !== 1'b1) begin n_fail++; $display("FAIL dmaw_done act=%b exp=1", i1.dma_done); end
        n_chk++; if (i1.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL dmaw_gnt3 act=%b exp=0", i1.dma_gnt); end
        next_cycle();
        i1.cpu_re = 1'b1; i1.cpu_addr = 16'h00FF;
        #1;
        n_chk++; if (i1.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL dmaw_cpu_stall act=%b exp=1", i1.cpu_stall); end
        n_chk++; if (i1.dma_done !== 1'b0) begin n_fail++; $display("FAIL dmaw_done_pulse act=%b exp=0", i1.dma_done); end
        next_cycle();
        #1;
        n_chk++; if (i1.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL dmaw_cpu_stall2 act=%b exp=0", i1.cpu_stall); end
        n_chk++; if (i1.cpu_rdata !== 4'h3) begin n_fail++; $display("FAIL dmaw_readback act=%h exp=3", i1.cpu_rdata); end
        next_cycle();
        i1.cpu_re = 1'b0;
        $display("dma_write: 3 @00ff, cpu readback %h", i1.cpu_rdata);
    endtask

    task automatic test_burst_limit();
        // Two rounds: CPU, CPU, DMA, then done cycle with dma_req dropped.
        logic [15:0] dma_a [2];
        logic [3:0]  dma_d [2];
        logic        exp_gnt [3];
        dma_a[0] = 16'h0020; dma_a[1] = 16'h0021;
        dma_d[0] = 4'h7;     dma_d[1] = 4'hC;
        exp_gnt[0] = 1'b0; exp_gnt[1] = 1'b0; exp_gnt[2] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                next_cycle();
                ib.cpu_re = 1'b1; ib.cpu_addr = 16'h0010;
                ib.dma_req = 1'b1; ib.dma_we = 1'b0; ib.dma_addr = dma_a[r];
                #1;
                n_chk++; if (ib.dma_gnt !== exp_gnt[c]) begin n_fail++; $display("FAIL burst_gnt r%0d c%0d act=%b exp=%b", r, c, ib.dma_gnt, exp_gnt[c]); end
                n_chk++; if (ib.cpu_stall !== exp_gnt[c]) begin n_fail++; $display("FAIL burst_stall r%0d c%0d act=%b exp=%b", r, c, ib.cpu_stall, exp_gnt[c]); end
            end
            next_cycle();
            ib.dma_req = 1'b0;
            #1;
            n_chk++; if (ib.dma_done !== 1'b1) begin n_fail++; $display("FAIL burst_done r%0d act=%b exp=1", r, ib.dma_done); end
            n_chk++; if (ib.dma_rdata !== dma_d[r]) begin n_fail++; $display("FAIL burst_rdata r%0d act=%h exp=%h", r, ib.dma_rdata, dma_d[r]); end
            n_chk++; if (ib.cpu_rdata !== 4'h1) begin n_fail++; $display("FAIL burst_cpu_rdata r%0d act=%h exp=1", r, ib.cpu_rdata); end
            $display("burst_limit: round %0d dma_rdata %h", r, ib.dma_rdata);
        end
        next_cycle();
        ib.cpu_re = 1'b0;
    endtask

    task automatic test_dma_always_wins();
        next_cycle();
        iz.cpu_we = 1'b1; iz.cpu_addr = 16'h0030; iz.cpu_wdata = 4'h9;
        iz.dma_req = 1'b1; iz.dma_we = 1'b0; iz.dma_addr = 16'h0031;
        #1;
        n_chk++; if (iz.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL bm0_gnt1 act=%b exp=1", iz.dma_gnt); end
        n_chk++; if (iz.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL bm0_stall1 act=%b exp=1", iz.cpu_stall); end
        n_chk++; if (iz.mem_addr !== 16'h0031) begin n_fail++; $display("FAIL bm0_addr1 act=%h exp=0031", iz.mem_addr); end
        next_cycle();
        #1;
        n_chk++; if (iz.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL bm0_stall2 act=%b exp=1", iz.cpu_stall); end
        n_chk++; if (iz.mem_re !== 1'b1) begin n_fail++; $display("FAIL bm0_re2 act=%b exp=1", iz.mem_re); end
        next_cycle();
        iz.dma_req = 1'b0;
        #1;
        n_chk++; if (iz.dma_done !== 1'b1) begin n_fail++; $display("FAIL bm0_done act=%b exp=1", iz.dma_done); end
        n_chk++; if (iz.dma_rdata !== 4'h6) begin n_fail++; $display("FAIL bm0_rdata act=%h exp=6", iz.dma_rdata); end
        n_chk++; if (iz.mem_addr !== 16'h0030) begin n_fail++; $display("FAIL bm0_cpu_addr act=%h exp=0030", iz.mem_addr); end
        n_chk++; if (iz.mem_we !== 1'b0) begin n_fail++; $display("FAIL bm0_we3 act=%b exp=0", iz.mem_we); end
        n_chk++; if (iz.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL bm0_stall3 act=%b exp=1", iz.cpu_stall); end
        next_cycle();
        #1;
        n_chk++; if (iz.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL bm0_stall4 act=%b exp=0", iz.cpu_stall); end
        n_chk++; if (iz.mem_we !== 1'b1) begin n_fail++; $display("FAIL bm0_we4 act=%b exp=1", iz.mem_we); end
        next_cycle();
        iz.cpu_we = 1'b0;
        #1;
        n_chk++; if (memz[16'h0030] !== 4'h9) begin n_fail++; $display("FAIL bm0_written act=%h exp=9", memz[16'h0030]); end
        $display("dma_always_wins: dma read %h, cpu wrote %h", iz.dma_rdata, memz[16'h0030]);
    endtask

    task automatic test_reset_mid_dma();
        next_cycle();
        i2.dma_req = 1'b1; i2.dma_we = 1'b0; i2.dma_addr = 16'h0040;
        #1;
        n_chk++; if (i2.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt0 act=%b exp=1", i2.dma_gnt); end
        next_cycle();
        rst = 1'b0; i2.dma_req = 1'b0;
        #1;
        n_chk++; if (i2.mem_re !== 1'b0) begin n_fail++; $display("FAIL rmid_re act=%b exp=0", i2.mem_re); end
        n_chk++; if (i2.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt act=%b exp=0", i2.dma_gnt); end
        n_chk++; if (i2.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_stall act=%b exp=1", i2.cpu_stall); end
        next_cycle();
        rst = 1'b1;
        #1;
        n_chk++; if (i2.dma_done !== 1'b0) begin n_fail++; $display("FAIL rmid_done act=%b exp=0", i2.dma_done); end
        n_chk++; if (i2.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_gnt act=%b exp=0", i2.dma_gnt); end
        n_chk++; if (i2.mem_re !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_re act=%b exp=0", i2.mem_re); end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            i2.dma_req = 1'b1; i2.dma_addr = 16'h0040;
            #1;
            n_chk++; if (i2.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_new_gnt c%0d act=%b exp=1", c, i2.dma_gnt); end
            n_chk++; if (i2.dma_done !== 1'b0) begin n_fail++; $display("FAIL rmid_new_done c%0d act=%b exp=0", c, i2.dma_done); end
        end
        next_cycle();
        i2.dma_req = 1'b0;
        #1;
        n_chk++; if (i2.dma_done !== 1'b1) begin n_fail++; $display("FAIL rmid_new_done act=%b exp=1", i2.dma_done); end
        n_chk++; if (i2.dma_rdata !== 4'hA) begin n_fail++; $display("FAIL rmid_new_rdata act=%h exp=a", i2.dma_rdata); end
        $display("reset_mid_dma: new dma read %h", i2.dma_rdata);
    endtask

    initial begin
        mem2[16'h0040] <= 4'hA;
        memb[16'h0010] <= 4'h1;
        memb[16'h0020] <= 4'h7;
        memb[16'h0021] <= 4'hC;
        memz[16'h0031] <= 4'h6;
    end

    initial begin
        i0.cpu_re = 0; i0.cpu_we = 0; i0.cpu_addr = 0; i0.cpu_wdata = 0; i0.dma_req = 0; i0.dma_we = 0; i0.dma_addr = 0; i0.dma_wdata = 0;
        i1.cpu_re = 0; i1.cpu_we = 0; i1.cpu_addr = 0; i1.cpu_wdata = 0; i1.dma_req = 0; i1.dma_we = 0; i1.dma_addr = 0; i1.dma_wdata = 0;
        i2.cpu_re = 0; i2.cpu_we = 0; i2.cpu_addr = 0; i2.cpu_wdata = 0; i2.dma_req = 0; i2.dma_we = 0; i2.dma_addr = 0; i2.dma_wdata = 0;
        ib.cpu_re = 0; ib.cpu_we = 0; ib.cpu_addr = 0; ib.cpu_wdata = 0; ib.dma_req = 0; ib.dma_we = 0; ib.dma_addr = 0; ib.dma_wdata = 0;
        iz.cpu_re = 0; iz.cpu_we = 0; iz.cpu_addr = 0; iz.cpu_wdata = 0; iz.dma_req = 0; iz.dma_we = 0; iz.dma_addr = 0; iz.dma_wdata = 0;
        test_reset();
        test_ws0_cpu();
        test_ws2_cpu_read();
        test_dma_write();
        test_burst_limit();
        test_dma_always_wins();
        test_reset_mid_dma();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
